// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared multiply/divide op encodings, default latencies and FSM states
package md_pkg;

  // md_op encodings, shared with the decoder's MUL_SEL field
  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  // Default busy durations in cycles
  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_t;

endpackage

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle mult/div unit holding the architectural HI/LO registers
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic        we,
  input  logic        we_hi,
  input  logic        hl_sel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] out
);

  localparam int CW = 16;

  md_state_t       state;
  logic [CW-1:0]   cnt;
  logic [31:0]     hi_r;
  logic [31:0]     lo_r;
  logic [31:0]     pend_hi;
  logic [31:0]     pend_lo;
  logic            pend_ok;

  logic            signed_op;
  logic            is_mul;
  logic            neg_a;
  logic            neg_b;
  logic [63:0]     prod;
  logic [31:0]     mag_a;
  logic [31:0]     mag_b;
  logic [31:0]     uq;
  logic [31:0]     ur;
  logic [31:0]     res_hi;
  logic [31:0]     res_lo;
  logic            res_ok;
  logic [CW-1:0]   res_cnt;

  // Result of the requested operation on the current operands; division works on
  // magnitudes so that INT_MIN / -1 wraps cleanly instead of overflowing.
  always_comb begin
    signed_op = (md_op == MD_MULT) || (md_op == MD_DIV);
    is_mul    = (md_op == MD_MULT) || (md_op == MD_MULTU);
    neg_a     = signed_op & a[31];
    neg_b     = signed_op & b[31];
    prod      = signed_op ? ({{32{a[31]}}, a} * {{32{b[31]}}, b})
                          : ({32'b0, a} * {32'b0, b});
    mag_a     = neg_a ? (~a + 32'd1) : a;
    mag_b     = neg_b ? (~b + 32'd1) : b;
    uq        = '0;
    ur        = '0;
    if (mag_b != 32'd0) begin
      uq = mag_a / mag_b;
      ur = mag_a % mag_b;
    end
    res_hi  = '0;
    res_lo  = '0;
    res_ok  = 1'b1;
    res_cnt = CW'(MULT_CYCLES);
    if (is_mul) begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end else begin
      res_hi  = neg_a ? (~ur + 32'd1) : ur;
      res_lo  = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
      res_ok  = (b != 32'd0);
      res_cnt = CW'(DIV_CYCLES);
    end
  end

  // Counter FSM: capture result on start, count down, commit to HI/LO on the last busy cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= MD_IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      hi_r    <= '0;
      lo_r    <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_ok <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            pend_ok <= res_ok;
            cnt     <= res_cnt;
            busy    <= 1'b1;
            state   <= MD_RUN;
          end else if (we) begin
            if (we_hi) hi_r <= a;
            else       lo_r <= a;
          end
        end
        MD_RUN: begin
          if (cnt <= CW'(1)) begin
            if (pend_ok) begin
              hi_r <= pend_hi;
              lo_r <= pend_lo;
            end
            cnt   <= '0;
            busy  <= 1'b0;
            state <= MD_IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= MD_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign out = hl_sel ? hi_r : lo_r;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - self-checking bench for md_unit: vector table, corner sequences, random ops
module tb_md_unit;
  import md_pkg::*;

  localparam int NM = 5;
  localparam int ND = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  md_op;
  logic        we;
  logic        we_hi;
  logic        hl_sel;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] out;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] ehi;
    logic [31:0] elo;
    bit          with_we;
    bit          disturb;
  } vec_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  md_unit #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .md_op  (md_op),
    .we     (we),
    .we_hi  (we_hi),
    .hl_sel (hl_sel),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .out    (out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic read_hl(input string name, input logic [31:0] ehi, input logic [31:0] elo);
    hl_sel = 1'b1;
    #1;
    chk({name, " hi"}, out, ehi);
    hl_sel = 1'b0;
    #1;
    chk({name, " lo"}, out, elo);
  endtask

  // Architectural reference: 64-bit arithmetic, division truncating toward zero
  function automatic void ref_op(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                                 inout logic [31:0] hi, inout logic [31:0] lo);
    longint      sx;
    longint      sy;
    longint      sp;
    longint      sq;
    longint      sr;
    logic [63:0] up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (op)
      MD_MULT: begin
        sp = sx * sy;
        hi = sp[63:32];
        lo = sp[31:0];
      end
      MD_MULTU: begin
        up = {32'b0, x} * {32'b0, y};
        hi = up[63:32];
        lo = up[31:0];
      end
      MD_DIV: begin
        if (y != 32'd0) begin
          sq = sx / sy;
          sr = sx % sy;
          hi = sr[31:0];
          lo = sq[31:0];
        end
      end
      default: begin
        if (y != 32'd0) begin
          hi = x % y;
          lo = x / y;
        end
      end
    endcase
  endfunction

  // Called at a negedge (cycle c); returns at the negedge of cycle c+N+1 after checking commit
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] x,
                        input logic [31:0] y, input bit with_we, input bit disturb);
    int          n;
    logic [31:0] nh;
    logic [31:0] nl;
    n  = (op == MD_MULT || op == MD_MULTU) ? NM : ND;
    nh = m_hi;
    nl = m_lo;
    ref_op(op, x, y, nh, nl);
    start = 1'b1;
    md_op = op;
    a     = x;
    b     = y;
    we    = with_we;
    we_hi = 1'b0;
    @(negedge clk);
    start = 1'b0;
    we    = 1'b0;
    a     = $urandom;
    b     = $urandom;
    for (int i = 0; i < n; i++) begin
      chk({name, " busy"}, {31'b0, busy}, 32'd1);
      read_hl({name, " hidden"}, m_hi, m_lo);
      if (disturb && i == 1) begin
        start = 1'b1;
        md_op = MD_MULTU;
        we    = 1'b1;
        we_hi = 1'b1;
        a     = 32'hDEADBEEF;
      end else begin
        start = 1'b0;
        we    = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    we    = 1'b0;
    chk({name, " busy end"}, {31'b0, busy}, 32'd0);
    m_hi = nh;
    m_lo = nl;
    read_hl({name, " commit"}, m_hi, m_lo);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{"mult",       MD_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 1'b0};
    vecs[1]  = '{"multu",      MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0};
    vecs[2]  = '{"div",        MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0};
    vecs[3]  = '{"divu",       MD_DIVU,  32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, 1'b0, 1'b0};
    vecs[4]  = '{"div0",       MD_DIV,   32'd5,        32'd0,        32'h00000001, 32'h7FFFFFFC, 1'b0, 1'b0};
    vecs[5]  = '{"divmin",     MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0};
    vecs[6]  = '{"mult_dist",  MD_MULT,  32'd3,        32'd4,        32'h00000000, 32'h0000000C, 1'b0, 1'b1};
    vecs[7]  = '{"divu0_we",   MD_DIVU,  32'd100,      32'd0,        32'h00000000, 32'h0000000C, 1'b1, 1'b1};
    vecs[8]  = '{"divmin3",    MD_DIV,   32'h80000000, 32'd3,        32'hFFFFFFFE, 32'hD5555556, 1'b0, 1'b0};
    vecs[9]  = '{"multu_big",  MD_MULTU, 32'h80000000, 32'd2,        32'h00000001, 32'h00000000, 1'b1, 1'b0};
    vecs[10] = '{"mult_min",   MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0};

    reset_n = 1'b0;
    start   = 1'b0;
    md_op   = MD_MULT;
    we      = 1'b0;
    we_hi   = 1'b0;
    hl_sel  = 1'b0;
    a       = '0;
    b       = '0;
    m_hi    = '0;
    m_lo    = '0;
    #12;
    chk("reset busy", {31'b0, busy}, 32'd0);
    read_hl("reset", 32'd0, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // mthi then mtlo, each readable in the following cycle
    we = 1'b1; we_hi = 1'b1; a = 32'h12345678;
    @(negedge clk);
    we = 1'b0;
    hl_sel = 1'b1;
    #1;
    chk("mthi", out, 32'h12345678);
    we = 1'b1; we_hi = 1'b0; a = 32'h9ABCDEF0;
    @(negedge clk);
    we = 1'b0;
    m_hi = 32'h12345678;
    m_lo = 32'h9ABCDEF0;
    read_hl("mtlo", m_hi, m_lo);

    // Vector table, issued back to back
    foreach (vecs[i]) begin
      run_op(vecs[i].name, vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].with_we, vecs[i].disturb);
      read_hl({vecs[i].name, " table"}, vecs[i].ehi, vecs[i].elo);
    end

    // Reset asserted in cycle 3 of a mult aborts it
    start = 1'b1; md_op = MD_MULT; a = 32'd7; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort busy", {31'b0, busy}, 32'd0);
    read_hl("abort", 32'd0, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    m_hi = '0;
    m_lo = '0;
    repeat (8) @(negedge clk);
    chk("abort later busy", {31'b0, busy}, 32'd0);
    read_hl("abort later", 32'd0, 32'd0);

    // Random operations against the reference model
    for (int k = 0; k < 30; k++) begin
      logic [1:0]  op;
      logic [31:0] x;
      logic [31:0] y;
      op = 2'($urandom_range(0, 3));
      x  = $urandom;
      y  = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: y = 32'($urandom_range(1, 16));
        2: y = 32'hFFFFFFFF;
        3: x = 32'h80000000;
        default: ;
      endcase
      if (k % 5 == 0) begin
        we = 1'b1; we_hi = k[0]; a = $urandom;
        @(negedge clk);
        we = 1'b0;
        if (we_hi) m_hi = a;
        else       m_lo = a;
        read_hl("rand mt", m_hi, m_lo);
      end
      run_op("rand", op, x, y, 1'b0, (k % 7) == 3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
